// File: rtl/peak_capture_pkg.sv
// Shared types and constants for the filter peak capture stage.
// DATA_W tracks the ADC width and trapezoid M length of the v10 filter.
package peak_capture_pkg;

  // Values mirrored from package_settings / v10_filter_parameters.
  localparam int SIZE_ADC_DATA  = 14;
  localparam int M_LENGTH_VAR10 = 7;
  localparam int DATA_W = SIZE_ADC_DATA + M_LENGTH_VAR10 + 1;
  localparam int TS_W   = 32;

  localparam int FLAG_TOO_LONG = 0;
  localparam int FLAG_PILE_UP  = 1;

  typedef enum logic [1:0] {
    IDLE,
    TRACK,
    HOLD
  } pc_state_t;

  typedef struct packed {
    logic signed [DATA_W-1:0] amp;
    logic [TS_W-1:0]          stamp;
    logic [1:0]               flags;
  } peak_event_t;

  function automatic logic [1:0] mk_flags(
    input logic too_long,
    input logic pile_up
  );
    logic [1:0] f;
    f = '0;
    f[FLAG_TOO_LONG] = too_long;
    f[FLAG_PILE_UP]  = pile_up;
    return f;
  endfunction

endpackage

// File: rtl/peak_event_slot.sv
// Single-entry event register towards the readout FIFO.
// Holds one event under valid/ready; drops and counts overflow events.
module peak_event_slot
  import peak_capture_pkg::*;
#(
  parameter int LOST_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              emit,
  input  peak_event_t       ev,
  input  logic              out_ready,
  output logic              out_valid,
  output peak_event_t       payload,
  output logic [LOST_W-1:0] lost_cnt
);

  logic take;
  logic drop;

  // A free slot or a same-cycle accept lets the new event in.
  assign take = emit && (!out_valid || out_ready);
  assign drop = emit && out_valid && !out_ready;

  // Slot contents and valid flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      payload   <= '0;
    end else if (take) begin
      out_valid <= 1'b1;
      payload   <= ev;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Saturating count of events lost to a stalled consumer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lost_cnt <= '0;
    end else if (drop && lost_cnt != '1) begin
      lost_cnt <= lost_cnt + LOST_W'(1);
    end
  end

endmodule

// File: rtl/filter_peak_capture.sv
// Pulse finder behind the trapezoidal filter.
// Tracks each pulse's peak and hands one event per pulse to the slot.
module filter_peak_capture
  import peak_capture_pkg::*;
#(
  parameter int THRESHOLD = 512,
  parameter int HYST      = 64,
  parameter int HOLDOFF   = 16,
  parameter int MAX_WIDTH = 255,
  parameter int LOST_W    = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] filter_data,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] peak_amp,
  output logic [TS_W-1:0]          peak_time,
  output logic [1:0]               peak_flags,
  output logic                     busy,
  output logic [LOST_W-1:0]        lost_cnt
);

  localparam int WID_W = $clog2(MAX_WIDTH + 1);
  localparam int HC_W  = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

  localparam logic signed [DATA_W:0] ARM_LVL =
    (DATA_W+1)'(THRESHOLD);
  localparam logic signed [DATA_W:0] END_LVL =
    (DATA_W+1)'(THRESHOLD - HYST);
  localparam logic [WID_W-1:0] WID_MAX = WID_W'(MAX_WIDTH);
  localparam logic [HC_W-1:0]  HC_LAST =
    HC_W'((HOLDOFF > 1) ? HOLDOFF - 1 : 0);

  logic signed [DATA_W-1:0] d_q;
  logic signed [DATA_W:0]   d_x;
  logic [TS_W-1:0]          ts;
  logic [TS_W-1:0]          t_cur;

  pc_state_t                state, state_n;
  logic signed [DATA_W-1:0] max_q, max_n;
  logic [TS_W-1:0]          tmax_q, tmax_n;
  logic [WID_W-1:0]         width_q, width_n;
  logic                     pu_q, pu_n;
  logic                     pend_q, pend_n;
  logic [HC_W-1:0]          hcnt_q, hcnt_n;

  logic                     above;
  logic                     below;
  logic                     emit;
  peak_event_t              ev;
  peak_event_t              payload;

  // d_q was captured one edge ago, so its stamp is ts minus one.
  assign t_cur = ts - TS_W'(1);
  assign d_x   = {d_q[DATA_W-1], d_q};
  assign above = d_x > ARM_LVL;
  assign below = d_x < END_LVL;
  assign busy  = (state != IDLE);

  // Input register and free-running timestamp.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      d_q <= '0;
      ts  <= '0;
    end else begin
      d_q <= filter_data;
      ts  <= ts + TS_W'(1);
    end
  end

  // FSM state and pulse tracker registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      max_q   <= '0;
      tmax_q  <= '0;
      width_q <= '0;
      pu_q    <= 1'b0;
      pend_q  <= 1'b0;
      hcnt_q  <= '0;
    end else begin
      state   <= state_n;
      max_q   <= max_n;
      tmax_q  <= tmax_n;
      width_q <= width_n;
      pu_q    <= pu_n;
      pend_q  <= pend_n;
      hcnt_q  <= hcnt_n;
    end
  end

  // Next-state, max tracking and event emission.
  always_comb begin
    state_n  = state;
    max_n    = max_q;
    tmax_n   = tmax_q;
    width_n  = width_q;
    pu_n     = pu_q;
    pend_n   = pend_q;
    hcnt_n   = hcnt_q;
    emit     = 1'b0;
    ev.amp   = max_q;
    ev.stamp = tmax_q;
    ev.flags = mk_flags(1'b0, pu_q);
    unique case (state)
      IDLE: begin
        if (above) begin
          state_n = TRACK;
          max_n   = d_q;
          tmax_n  = t_cur;
          width_n = WID_W'(1);
          pu_n    = pend_q;
          pend_n  = 1'b0;
        end
      end
      TRACK: begin
        if (below) begin
          emit    = 1'b1;
          state_n = HOLD;
          hcnt_n  = '0;
        end else begin
          if (d_q > max_q) begin
            max_n  = d_q;
            tmax_n = t_cur;
          end
          width_n = width_q + WID_W'(1);
          if (width_n == WID_MAX) begin
            emit     = 1'b1;
            ev.amp   = max_n;
            ev.stamp = tmax_n;
            ev.flags = mk_flags(1'b1, pu_q);
            state_n  = HOLD;
            hcnt_n   = '0;
          end
        end
      end
      HOLD: begin
        if (above) begin
          pend_n = 1'b1;
        end
        if (hcnt_q == HC_LAST) begin
          state_n = IDLE;
        end else begin
          hcnt_n = hcnt_q + HC_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  peak_event_slot #(
    .LOST_W(LOST_W)
  ) u_slot (
    .clk      (clk),
    .reset    (reset),
    .emit     (emit),
    .ev       (ev),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .payload  (payload),
    .lost_cnt (lost_cnt)
  );

  assign peak_amp   = payload.amp;
  assign peak_time  = payload.stamp;
  assign peak_flags = payload.flags;

endmodule

// File: tb/tb_filter_peak_capture.sv
// Bench for filter_peak_capture: directed pulses plus random pulses,
// checked cycle by cycle against a pulse-level reference model.
module tb_filter_peak_capture;
  import peak_capture_pkg::*;

  localparam int TH = 512;
  localparam int HY = 64;
  localparam int HO = 16;
  localparam int MW = 255;
  localparam int LW = 16;

  logic                     clk = 1'b0;
  logic                     reset = 1'b0;
  logic signed [DATA_W-1:0] filter_data = '0;
  logic                     out_ready = 1'b0;
  logic                     out_valid;
  logic signed [DATA_W-1:0] peak_amp;
  logic [TS_W-1:0]          peak_time;
  logic [1:0]               peak_flags;
  logic                     busy;
  logic [LW-1:0]            lost_cnt;

  always #5 clk = ~clk;

  filter_peak_capture #(
    .THRESHOLD(TH),
    .HYST     (HY),
    .HOLDOFF  (HO),
    .MAX_WIDTH(MW),
    .LOST_W   (LW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .filter_data(filter_data),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .peak_amp   (peak_amp),
    .peak_time  (peak_time),
    .peak_flags (peak_flags),
    .busy       (busy),
    .lost_cnt   (lost_cnt)
  );

  typedef struct {
    int     amp;
    longint tm;
    int     flags;
    int     at;
  } tev_t;

  int   xs[$];
  bit   rs[$];
  bit   mbusy[$];
  tev_t mev[$];
  tev_t dev[$];

  int nvec = 0;
  int nerr = 0;
  int probe_k = -1;
  int probe_lost = -1;

  task automatic chk(input string tag, input longint got,
                     input longint exp);
    nvec++;
    if (got != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push(input int v, input bit r);
    xs.push_back(v);
    rs.push_back(r);
  endtask

  task automatic put(input int v, input int n);
    repeat (n) push(v, 1'b1);
  endtask

  // Pulse-level model: scan the sample list for pulses, then
  // derive event contents, emit edges and busy windows from them.
  task automatic build_model();
    int n;
    int j;
    int h;
    bit pend;
    n = xs.size();
    h = (HO < 1) ? 1 : HO;
    mev.delete();
    mbusy.delete();
    for (int i = 0; i < n; i++) mbusy.push_back(1'b0);
    pend = 1'b0;
    j = 0;
    while (j < n) begin
      if (xs[j] > TH) begin
        int s, e, w, amp, tm;
        bit tl, pile;
        s = j; e = -1; w = 1; tl = 1'b0;
        amp = xs[s]; tm = s;
        pile = pend; pend = 1'b0;
        for (int i = s + 1; i < n; i++) begin
          if (xs[i] < TH - HY) begin
            e = i;
            break;
          end
          w++;
          if (xs[i] > amp) begin
            amp = xs[i];
            tm = i;
          end
          if (w == MW) begin
            e = i;
            tl = 1'b1;
            break;
          end
        end
        if (e < 0) break;
        mev.push_back('{amp, longint'(tm),
                        (int'(pile) << 1) | int'(tl), e + 1});
        for (int i = e + 1; i <= e + h && i < n; i++)
          if (xs[i] > TH) pend = 1'b1;
        for (int k = s + 1; k <= e + h && k < n; k++)
          mbusy[k] = 1'b1;
        j = e + h + 1;
      end else begin
        j++;
      end
    end
  endtask

  // Reset, then play xs/rs and compare every cycle with the model.
  task automatic run_seg();
    int   n;
    int   ei;
    int   lost;
    bit   v;
    tev_t cur;
    n = xs.size();
    ei = 0; lost = 0; v = 1'b0;
    cur = '{0, 0, 0, 0};
    dev.delete();
    reset = 1'b0;
    filter_data = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    filter_data = DATA_W'(xs[0]);
    out_ready = rs[0];
    reset = 1'b1;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      if (ei < mev.size() && mev[ei].at == k) begin
        if (!v || rs[k]) begin
          cur = mev[ei];
          v = 1'b1;
        end else if (lost < (1 << LW) - 1) begin
          lost++;
        end
        ei++;
      end else if (v && rs[k]) begin
        v = 1'b0;
      end
      #1;
      chk("out_valid", longint'(out_valid), longint'(v));
      chk("lost_cnt", longint'(lost_cnt), longint'(lost));
      chk("busy", longint'(busy), longint'(mbusy[k]));
      if (v) begin
        chk("peak_amp", longint'(peak_amp), longint'(cur.amp));
        chk("peak_time", longint'(peak_time), cur.tm);
        chk("peak_flags", longint'(peak_flags), longint'(cur.flags));
      end
      if (k == probe_k) probe_lost = int'(lost_cnt);
      if (k + 1 < n) begin
        filter_data = DATA_W'(xs[k + 1]);
        out_ready = rs[k + 1];
      end
      if (out_valid && out_ready)
        dev.push_back('{int'(peak_amp), longint'(peak_time),
                        int'(peak_flags), k + 1});
    end
    chk("events_emitted", longint'(ei), longint'(mev.size()));
  endtask

  initial begin
    int t1000, tflat, tlong, r5, e4, tpk;
    int devn;

    // Segment A: directed pulses, stalled consumer, random pulses.
    put(0, 10);
    for (int v = 0; v <= 1000; v += 100) begin
      if (v == 1000) t1000 = xs.size();
      put(v, 1);
    end
    for (int v = 900; v >= 0; v -= 100) put(v, 1);
    put(0, 30);
    tflat = xs.size();
    put(1000, 20);
    put(0, 30);
    tlong = xs.size();
    put(600, 300);
    put(0, 40);
    put(1000, 3); put(0, 5); put(1000, 20); put(0, 30);
    put(900, 4); put(0, 30);
    r5 = xs.size();
    put(700, 3);  put(0, 30);
    put(800, 3);  put(0, 30);
    put(900, 3);  put(0, 30);
    put(1100, 3); put(0, 30);
    for (int p = 0; p < 12; p++) begin
      int up, pk;
      repeat ($urandom_range(25, 45))
        push(int'($urandom_range(0, 700)) - 300,
             $urandom_range(0, 9) < 7);
      pk = int'($urandom_range(520, 4000));
      up = int'($urandom_range(1, 4));
      for (int i = 1; i <= up; i++)
        push(pk * i / up, $urandom_range(0, 9) < 7);
      repeat ($urandom_range(0, 4))
        push(pk - int'($urandom_range(0, 50)),
             $urandom_range(0, 9) < 7);
      for (int i = up - 1; i >= 0; i--)
        push(pk * i / up, $urandom_range(0, 9) < 7);
    end
    put(0, 40);
    build_model();
    e4 = (mev.size() > 10) ? mev[10].at : r5;
    for (int k = r5; k < e4; k++) rs[k] = 1'b0;
    probe_k = e4;
    run_seg();

    devn = dev.size();
    chk("dev_count_min", longint'(devn >= 9), 1);
    if (devn >= 9) begin
      chk("tri_amp", dev[0].amp, 1000);
      chk("tri_time", dev[0].tm, t1000);
      chk("tri_flags", dev[0].flags, 0);
      chk("flat_amp", dev[1].amp, 1000);
      chk("flat_time", dev[1].tm, tflat);
      chk("long_amp", dev[2].amp, 600);
      chk("long_time", dev[2].tm, tlong);
      chk("long_flags", dev[2].flags, 1);
      chk("pileup_flags", dev[5].flags, 2);
      chk("after_pu_flags", dev[6].flags, 0);
      chk("stall_first_amp", dev[7].amp, 700);
      chk("replace_amp", dev[8].amp, 1100);
      chk("replace_gap", dev[8].at - dev[7].at, 1);
    end
    chk("stall_lost", probe_lost, 2);

    // Reset while tracking a pulse.
    out_ready = 1'b1;
    filter_data = '0;
    @(negedge clk) filter_data = 400;
    @(negedge clk) filter_data = 800;
    @(negedge clk) filter_data = 800;
    @(negedge clk);
    chk("pre_reset_busy", longint'(busy), 1);
    #2 reset = 1'b0;
    #1;
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_lost", longint'(lost_cnt), 0);
    chk("rst_amp", longint'(peak_amp), 0);

    // Segment B: fresh timestamps after reset release.
    xs.delete();
    rs.delete();
    probe_k = -1;
    put(0, 20);
    put(300, 1); put(700, 1);
    tpk = xs.size();
    put(950, 1); put(600, 1); put(200, 1);
    put(0, 30);
    build_model();
    run_seg();
    chk("b_events", longint'(dev.size()), 1);
    if (dev.size() == 1) begin
      chk("b_amp", dev[0].amp, 950);
      chk("b_time", dev[0].tm, tpk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
